// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - per-channel pushbutton synchronizer, debouncer and press/release pulse generator
// Optional auto-repeat of press pulses while held: BUTTON_DEBOUNCE_AUTO_REPEAT_EN
module button_debounce #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_C  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int CW     = $clog2(MAX_C + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {ST_STABLE, ST_PENDING} state_e;

    logic [N_BTN-1:0] sync1_q, sync1_d;
    logic [N_BTN-1:0] sync2_q, sync2_d;
    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic [N_BTN-1:0] accept;
    state_e           state_q [N_BTN];
    state_e           state_d [N_BTN];
    logic [CW-1:0]    cnt_q   [N_BTN];
    logic [CW-1:0]    cnt_d   [N_BTN];

`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
    logic [CW-1:0]    rpt_q   [N_BTN];
    logic [CW-1:0]    rpt_d   [N_BTN];
    logic [N_BTN-1:0] armed_q, armed_d;
`endif

    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        accept    = '0;
`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
        armed_d   = '0;
`endif
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = '0;
            // Any cycle where the synchronized level disagrees advances the count;
            // agreeing again drops it back to zero so a bounce restarts the window.
            case (state_q[i])
                ST_STABLE: begin
                    if (sync2_q[i] != level_q[i]) begin
                        state_d[i] = ST_PENDING;
                        cnt_d[i]   = cnt_q[i] + CW'(1);
                    end
                end
                ST_PENDING: begin
                    if (sync2_q[i] == level_q[i]) begin
                        state_d[i] = ST_STABLE;
                    end else if (cnt_q[i] == DB_LAST) begin
                        state_d[i]   = ST_STABLE;
                        accept[i]    = 1'b1;
                        level_d[i]   = sync2_q[i];
                        press_d[i]   = sync2_q[i];
                        release_d[i] = ~sync2_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                default: state_d[i] = ST_STABLE;
            endcase
`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
            rpt_d[i] = '0;
            // Suppressed on the release edge so press and release never coincide.
            if (level_q[i] && !accept[i]) begin
                if (rpt_q[i] == (armed_q[i] ? RP_LAST : RD_LAST)) begin
                    press_d[i] = 1'b1;
                    armed_d[i] = 1'b1;
                end else begin
                    rpt_d[i]   = rpt_q[i] + CW'(1);
                    armed_d[i] = armed_q[i];
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
            armed_q <= '0;
            for (int i = 0; i < N_BTN; i++) rpt_q[i] <= '0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
            armed_q <= armed_d;
            for (int i = 0; i < N_BTN; i++) rpt_q[i] <= rpt_d[i];
`endif
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule
